// File: rtl/apb_mem_lru_subsystem.sv
// Cache-side memory subsystem.
// A three-state APB master bridge talks to a zero-wait-state 4 KB byte RAM.
// An independent per-set LRU age store sits alongside the bridge.
module apb_mem_lru_subsystem #(
   parameter int NUM_SETS    = 4,
   parameter int INDEX_WIDTH = 2,
   parameter int ADDR_WIDTH  = 12,
   parameter int LINE_BITS   = 512,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   transfer,
   input  logic                   readwrite,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [1:0]             dsize,
   input  logic [DATA_WIDTH-1:0]  write_data,
   output logic [LINE_BITS-1:0]   rd_line,
   output logic                   rd_ready,
   output logic                   wr_ready,
   output logic                   psel,
   output logic                   penable,
   output logic [1:0]             bridge_state,
   input  logic [INDEX_WIDTH-1:0] lru_index,
   input  logic                   lru_wen,
   input  logic [1:0]             lru_in0,
   input  logic [1:0]             lru_in1,
   input  logic [1:0]             lru_in2,
   input  logic [1:0]             lru_in3,
   output logic [1:0]             lru_out0,
   output logic [1:0]             lru_out1,
   output logic [1:0]             lru_out2,
   output logic [1:0]             lru_out3
);

   localparam int LINE_BYTES = LINE_BITS / 8;
   localparam int LINE_OFS   = $clog2(LINE_BYTES);

   // Request handshake: a request is accepted on any rising edge where
   // transfer=1 and the bridge is in IDLE or finishing ACCESS; its fields are
   // captured on that edge. Completion is a one-cycle rd_ready or wr_ready
   // pulse; there is no back-pressure, so the requester must not drop a pulse.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    rw_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [1:0]              dsize_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    pready;
   logic                    access_done;
   logic                    latch_req;
   logic [LINE_BITS-1:0]    line_data;
   logic [7:0]              mem [2**ADDR_WIDTH];
   logic [1:0]              lru_mem [NUM_SETS][4];

   // The RAM never inserts wait states.
   assign pready       = 1'b1;
   assign access_done  = (state_q == ACCESS) && pready;
   assign latch_req    = transfer && ((state_q == IDLE) || access_done);
   assign bridge_state = state_q;

   // Bridge state register and captured request fields.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         dsize_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            rw_q    <= readwrite;
            addr_q  <= addr;
            dsize_q <= dsize;
            wdata_q <= write_data;
         end
      end
   end

   // Next-state and APB phase outputs.
   always_comb begin
      state_d = state_q;
      psel    = 1'b0;
      penable = 1'b0;
      case (state_q)
         IDLE: begin
            if (transfer) state_d = SETUP;
         end
         SETUP: begin
            psel    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) state_d = transfer ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Completion pulses and the held read line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_line  <= '0;
         rd_ready <= 1'b0;
         wr_ready <= 1'b0;
      end else begin
         rd_ready <= access_done && !rw_q;
         wr_ready <= access_done && rw_q;
         if (access_done && !rw_q) rd_line <= line_data;
      end
   end

   // Gather the aligned line containing the captured address.
   always_comb begin
      line_data = '0;
      for (int k = 0; k < LINE_BYTES; k++) begin
         line_data[8*k +: 8] = mem[{addr_q[ADDR_WIDTH-1:LINE_OFS], LINE_OFS'(k)}];
      end
   end

   // RAM write on the ACCESS edge; sizes are aligned so nothing wraps.
   always_ff @(posedge clk) begin
      if (access_done && rw_q) begin
         case (dsize_q)
            2'b00: mem[addr_q] <= wdata_q[7:0];
            2'b01: begin
               mem[{addr_q[ADDR_WIDTH-1:1], 1'b0}] <= wdata_q[7:0];
               mem[{addr_q[ADDR_WIDTH-1:1], 1'b1}] <= wdata_q[15:8];
            end
            default: begin
               for (int i = 0; i < 4; i++) begin
                  mem[{addr_q[ADDR_WIDTH-1:2], 2'(i)}] <= wdata_q[8*i +: 8];
               end
            end
         endcase
      end
   end

   // LRU age store: reset to ages 0..3, synchronous whole-set write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < 4; w++) begin
               lru_mem[s][w] <= 2'(w);
            end
         end
      end else if (lru_wen) begin
         lru_mem[lru_index][0] <= lru_in0;
         lru_mem[lru_index][1] <= lru_in1;
         lru_mem[lru_index][2] <= lru_in2;
         lru_mem[lru_index][3] <= lru_in3;
      end
   end

   assign lru_out0 = lru_mem[lru_index][0];
   assign lru_out1 = lru_mem[lru_index][1];
   assign lru_out2 = lru_mem[lru_index][2];
   assign lru_out3 = lru_mem[lru_index][3];

endmodule

// File: tb/tb_apb_mem_lru_subsystem.sv
// Self-checking bench for apb_mem_lru_subsystem: byte-array RAM model,
// LRU age table model, directed vector table and randomized traffic.
module tb_apb_mem_lru_subsystem;

   logic         clk = 1'b0;
   logic         reset;
   logic         transfer;
   logic         readwrite;
   logic [11:0]  addr;
   logic [1:0]   dsize;
   logic [31:0]  write_data;
   logic [511:0] rd_line;
   logic         rd_ready;
   logic         wr_ready;
   logic         psel;
   logic         penable;
   logic [1:0]   bridge_state;
   logic [1:0]   lru_index;
   logic         lru_wen;
   logic [1:0]   lru_in0, lru_in1, lru_in2, lru_in3;
   logic [1:0]   lru_out0, lru_out1, lru_out2, lru_out3;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   ref_mem [4096];
   logic [1:0]   lru_ref [4][4];
   logic [511:0] exp_line;
   logic [511:0] exp_q [$];

   typedef struct {
      logic        rw;
      logic [11:0] a;
      logic [1:0]  ds;
      logic [31:0] wd;
      int          pos;
      logic [31:0] exp;
      logic [31:0] mask;
   } vec_t;

   vec_t vecs [11];

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   apb_mem_lru_subsystem dut (
      .clk          (clk),
      .reset        (reset),
      .transfer     (transfer),
      .readwrite    (readwrite),
      .addr         (addr),
      .dsize        (dsize),
      .write_data   (write_data),
      .rd_line      (rd_line),
      .rd_ready     (rd_ready),
      .wr_ready     (wr_ready),
      .psel         (psel),
      .penable      (penable),
      .bridge_state (bridge_state),
      .lru_index    (lru_index),
      .lru_wen      (lru_wen),
      .lru_in0      (lru_in0),
      .lru_in1      (lru_in1),
      .lru_in2      (lru_in2),
      .lru_in3      (lru_in3),
      .lru_out0     (lru_out0),
      .lru_out1     (lru_out1),
      .lru_out2     (lru_out2),
      .lru_out3     (lru_out3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard model: RAM as a plain byte array
   function automatic void ref_write(input logic [11:0] a, input logic [1:0] ds, input logic [31:0] wd);
      int base;
      case (ds)
         2'b00: ref_mem[int'(a)] = wd[7:0];
         2'b01: begin
            base = (int'(a) / 2) * 2;
            ref_mem[base]     = wd[7:0];
            ref_mem[base + 1] = wd[15:8];
         end
         default: begin
            base = (int'(a) / 4) * 4;
            for (int k = 0; k < 4; k++) ref_mem[base + k] = wd[8*k +: 8];
         end
      endcase
   endfunction

   function automatic logic [511:0] ref_line(input logic [11:0] a);
      logic [511:0] l;
      int base;
      base = (int'(a) / 64) * 64;
      for (int k = 0; k < 64; k++) l[8*k +: 8] = ref_mem[base + k];
      return l;
   endfunction

   function automatic logic [31:0] lru_pack_out();
      return {24'd0, lru_out3, lru_out2, lru_out1, lru_out0};
   endfunction

   function automatic logic [31:0] lru_pack_ref(input int idx);
      return {24'd0, lru_ref[idx][3], lru_ref[idx][2], lru_ref[idx][1], lru_ref[idx][0]};
   endfunction

   function automatic logic [31:0] bus_flags();
      return {28'd0, psel, penable, rd_ready, wr_ready};
   endfunction

   // driver: one isolated transaction with phase, latency and data checks
   task automatic single_txn(input logic rw, input logic [11:0] a, input logic [1:0] ds,
                             input logic [31:0] wd);
      chk("idle_phase", bus_flags(), 32'h0);
      transfer = 1'b1; readwrite = rw; addr = a; dsize = ds; write_data = wd;
      @(posedge clk); #1;
      transfer = 1'b0;
      readwrite = 1'($urandom_range(0, 1));
      addr = 12'($urandom);
      dsize = 2'($urandom);
      write_data = $urandom;
      chk("setup_phase", bus_flags(), 32'h8);
      @(posedge clk); #1;
      chk("access_phase", bus_flags(), 32'hC);
      @(posedge clk); #1;
      if (rw) begin
         ref_write(a, ds, wd);
         chk("wr_done", bus_flags(), 32'h1);
         chk_line("rd_line_hold", rd_line, exp_line);
      end else begin
         exp_line = ref_line(a);
         chk("rd_done", bus_flags(), 32'h2);
         chk_line("rd_line", rd_line, exp_line);
      end
      @(posedge clk); #1;
      chk("pulse_end", bus_flags(), 32'h0);
   endtask

   task automatic check_lru_defaults(input string name);
      for (int i = 0; i < 4; i++) begin
         lru_index = 2'(i);
         #1;
         chk(name, lru_pack_out(), 32'hE4);
         for (int w = 0; w < 4; w++) lru_ref[i][w] = 2'(w);
      end
   endtask

   initial begin
      int rdy_seen;
      int wr_cnt;
      logic [511:0] got;

      vecs[0]  = '{1'b1, 12'h044, 2'b10, 32'hDEADBEEF, 0,  32'h0,        32'h0};
      vecs[1]  = '{1'b0, 12'h07F, 2'b00, 32'h0,        4,  32'hDEADBEEF, 32'hFFFFFFFF};
      vecs[2]  = '{1'b1, 12'h101, 2'b00, 32'h0000005A, 0,  32'h0,        32'h0};
      vecs[3]  = '{1'b1, 12'h103, 2'b01, 32'h00001234, 0,  32'h0,        32'h0};
      vecs[4]  = '{1'b0, 12'h100, 2'b11, 32'h0,        1,  32'h0012345A, 32'h00FFFFFF};
      vecs[5]  = '{1'b1, 12'hFFF, 2'b11, 32'hA1B2C3D4, 0,  32'h0,        32'h0};
      vecs[6]  = '{1'b0, 12'hFC5, 2'b01, 32'h0,        60, 32'hA1B2C3D4, 32'hFFFFFFFF};
      vecs[7]  = '{1'b1, 12'h001, 2'b01, 32'h0000BEEF, 0,  32'h0,        32'h0};
      vecs[8]  = '{1'b0, 12'h03F, 2'b10, 32'h0,        0,  32'h0000BEEF, 32'h0000FFFF};
      vecs[9]  = '{1'b1, 12'h0C3, 2'b00, 32'h000000CD, 0,  32'h0,        32'h0};
      vecs[10] = '{1'b0, 12'h0C0, 2'b00, 32'h0,        3,  32'h000000CD, 32'h000000FF};

      reset = 1'b0; transfer = 1'b0; readwrite = 1'b0; addr = '0; dsize = '0;
      write_data = '0; lru_index = '0; lru_wen = 1'b0;
      lru_in0 = '0; lru_in1 = '0; lru_in2 = '0; lru_in3 = '0;
      exp_line = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", bus_flags(), 32'h0);
      chk_line("reset_rd_line", rd_line, '0);
      check_lru_defaults("reset_lru");
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // fill the whole RAM with back-to-back word writes
      wr_cnt = 0;
      transfer = 1'b1; readwrite = 1'b1; dsize = 2'b10; addr = 12'h000; write_data = $urandom;
      ref_write(addr, dsize, write_data);
      @(posedge clk); #1;
      for (int i = 1; i <= 1024; i++) begin
         @(posedge clk); #1;
         if (i < 1024) begin
            addr = 12'(i * 4);
            write_data = $urandom;
            ref_write(addr, dsize, write_data);
         end else begin
            transfer = 1'b0;
         end
         @(posedge clk); #1;
         if (wr_ready) wr_cnt++;
      end
      chk("fill_wr_pulses", 32'(wr_cnt), 32'd1024);
      @(posedge clk); #1;

      // directed vector table
      for (int v = 0; v < 11; v++) begin
         single_txn(vecs[v].rw, vecs[v].a, vecs[v].ds, vecs[v].wd);
         if (!vecs[v].rw) begin
            chk($sformatf("vec%0d_field", v), rd_line[8*vecs[v].pos +: 32] & vecs[v].mask,
                vecs[v].exp & vecs[v].mask);
         end
      end

      // back-to-back reads, scoreboard queue
      transfer = 1'b1; readwrite = 1'b0; addr = 12'h000;
      exp_q.push_back(ref_line(12'h000));
      @(posedge clk); #1;
      addr = 12'h040;
      exp_q.push_back(ref_line(12'h040));
      @(posedge clk); #1;
      chk("b2b_access1", bus_flags(), 32'hC);
      @(posedge clk); #1;
      transfer = 1'b0;
      addr = 12'($urandom);
      chk("b2b_first_done", bus_flags(), 32'hA);
      got = exp_q.pop_front();
      chk_line("b2b_line0", rd_line, got);
      @(posedge clk); #1;
      chk("b2b_access2", bus_flags(), 32'hC);
      @(posedge clk); #1;
      chk("b2b_second_done", bus_flags(), 32'h2);
      got = exp_q.pop_front();
      chk_line("b2b_line1", rd_line, got);
      exp_line = got;
      @(posedge clk); #1;

      // directed LRU write at index 2
      lru_index = 2'd2; lru_in0 = 2'd3; lru_in1 = 2'd2; lru_in2 = 2'd1; lru_in3 = 2'd0;
      lru_wen = 1'b1;
      #1;
      chk("lru_before_edge", lru_pack_out(), 32'hE4);
      @(posedge clk); #1;
      lru_wen = 1'b0;
      chk("lru_after_edge", lru_pack_out(), 32'h1B);
      lru_ref[2][0] = 2'd3; lru_ref[2][1] = 2'd2; lru_ref[2][2] = 2'd1; lru_ref[2][3] = 2'd0;
      for (int i = 0; i < 4; i++) begin
         lru_index = 2'(i);
         #1;
         chk($sformatf("lru_idx%0d", i), lru_pack_out(), lru_pack_ref(i));
      end

      // random LRU traffic against the age table
      for (int n = 0; n < 24; n++) begin
         lru_index = 2'($urandom_range(0, 3));
         lru_wen = 1'($urandom_range(0, 1));
         lru_in0 = 2'($urandom); lru_in1 = 2'($urandom);
         lru_in2 = 2'($urandom); lru_in3 = 2'($urandom);
         #1;
         chk("lru_rand_old", lru_pack_out(), lru_pack_ref(int'(lru_index)));
         @(posedge clk); #1;
         if (lru_wen) begin
            lru_ref[lru_index][0] = lru_in0; lru_ref[lru_index][1] = lru_in1;
            lru_ref[lru_index][2] = lru_in2; lru_ref[lru_index][3] = lru_in3;
         end
         chk("lru_rand_new", lru_pack_out(), lru_pack_ref(int'(lru_index)));
      end
      lru_wen = 1'b0;

      // random bridge traffic
      for (int n = 0; n < 40; n++) begin
         single_txn(1'($urandom_range(0, 1)), 12'($urandom), 2'($urandom), $urandom);
      end
      single_txn(1'b0, 12'h200, 2'b00, 32'h0);

      // reset asserted during ACCESS drops the write
      transfer = 1'b1; readwrite = 1'b1; addr = 12'h204; dsize = 2'b10;
      write_data = ~ref_mem[12'h204] == 8'h0 ? 32'h11223344 : 32'h55667788;
      @(posedge clk); #1;
      transfer = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_access", bus_flags(), 32'hC);
      reset = 1'b0;
      #1;
      chk("abort_flags", bus_flags(), 32'h0);
      chk_line("abort_rd_line", rd_line, '0);
      exp_line = '0;
      @(posedge clk); #1;
      check_lru_defaults("reset_mid_lru");
      @(negedge clk) reset = 1'b1;
      rdy_seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (rd_ready || wr_ready || psel) rdy_seen++;
      end
      chk("abort_no_pulse", 32'(rdy_seen), 32'd0);
      single_txn(1'b0, 12'h204, 2'b00, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
